uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter: successor to the fixed 8N1 push-button transmitter.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serializer with configurable width, parity and stop bits.
// First start bit one cycle after a push into an idle, empty block; in_ready low only while full.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        txd,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [IW-1:0]        data_idx, data_idx_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] head;
  logic                 par, par_nxt;
  logic                 txd_nxt;
  logic                 push, pop, start_frame, bit_wrap, has_word;

  assign in_ready   = level < FULL_LVL;
  assign push       = in_valid && in_ready;
  assign has_word   = level != '0;
  assign head       = mem[rd_ptr];
  assign bit_wrap   = bit_cnt == BIT_LAST;
  assign busy       = state != IDLE;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    data_idx_nxt = data_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    par_nxt      = par;
    txd_nxt      = txd;
    start_frame  = 1'b0;
    pop          = 1'b0;
    tx_done      = 1'b0;

    if (state != IDLE) bit_cnt_nxt = bit_wrap ? '0 : bit_cnt + 1'b1;

    case (state)
      IDLE: start_frame = has_word;
      START: begin
        if (bit_wrap) begin
          state_nxt    = DATA;
          data_idx_nxt = '0;
          txd_nxt      = shreg[0];
          shreg_nxt    = shreg >> 1;
        end
      end
      DATA: begin
        if (bit_wrap) begin
          if (data_idx != IDX_LAST) begin
            data_idx_nxt = data_idx + 1'b1;
            txd_nxt      = shreg[0];
            shreg_nxt    = shreg >> 1;
          end else if (PARITY_EN != 0) begin
            state_nxt = PARITY;
            txd_nxt   = par;
          end else begin
            state_nxt    = STOP;
            stop_idx_nxt = 1'b0;
            txd_nxt      = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_wrap) begin
          state_nxt    = STOP;
          stop_idx_nxt = 1'b0;
          txd_nxt      = 1'b1;
        end
      end
      STOP: begin
        if (bit_wrap) begin
          if (stop_idx == STOP_LAST) begin
            tx_done = 1'b1;
            // Back-to-back frames: the next start bit follows the stop bit with no gap.
            if (has_word) begin
              start_frame = 1'b1;
            end else begin
              state_nxt = IDLE;
              txd_nxt   = 1'b1;
            end
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop         = 1'b1;
      shreg_nxt   = head;
      par_nxt     = (^head) ^ ODD;
      txd_nxt     = 1'b0;
      state_nxt   = START;
      bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_idx <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      data_idx <= data_idx_nxt;
      stop_idx <= stop_idx_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      txd      <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, a frame-level reference model and directed tests.
module tb_uart_tx_fifo;

  localparam int NC  = 4;
  localparam int CPB = 16;
  localparam int DEP = 4;
  localparam int CFG_DB [NC] = '{8, 8, 8, 7};
  localparam int CFG_PE [NC] = '{0, 1, 1, 0};
  localparam int CFG_PO [NC] = '{0, 0, 1, 0};
  localparam int CFG_SB [NC] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst;
  logic       in_valid_v [NC];
  logic [8:0] in_data_v  [NC];
  logic       txd_v      [NC];
  logic       busy_v     [NC];
  logic       done_v     [NC];
  logic       ready_v    [NC];
  logic [2:0] level_v    [NC];

  int  exp_txd   [NC];
  int  exp_busy  [NC];
  int  exp_done  [NC];
  int  exp_level [NC];
  int  exp_ready [NC];
  bit  started   [NC];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int k, input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0d want %0d", k, nm, act, want);
    end
  endtask

  genvar g;
  for (g = 0; g < NC; g++) begin : cfg
    localparam int DB = CFG_DB[g];
    localparam int PE = CFG_PE[g];
    localparam int PO = CFG_PO[g];
    localparam int SB = CFG_SB[g];
    localparam int FL = CPB * (1 + DB + PE + SB);

    int   q[$];
    int   pos;
    bit   active;
    logic fr [16];

    uart_tx_fifo #(
      .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_EN(PE),
      .PARITY_ODD(PO), .STOP_BITS(SB), .FIFO_DEPTH(DEP)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data_v[g][DB-1:0]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (ready_v[g]),
      .txd       (txd_v[g]),
      .busy      (busy_v[g]),
      .tx_done   (done_v[g]),
      .fifo_level(level_v[g])
    );

    // Frame-level model: a queue of words and a position inside the expanded bit list.
    initial begin
      int pre, w, p;
      bit push_ok;
      active = 0;
      pos    = 0;
      forever begin
        @(posedge clk);
        if (!rst) begin
          q.delete();
          active     = 0;
          pos        = 0;
          started[g] = 1;
        end else begin
          pre     = q.size();
          push_ok = in_valid_v[g] && (pre < DEP);
          if (active) begin
            pos++;
            if (pos == FL) active = 0;
          end
          if (!active && pre > 0) begin
            w = q.pop_front();
            p = PO;
            for (int i = 0; i < 16; i++) fr[i] = 1'b1;
            fr[0] = 1'b0;
            for (int i = 0; i < DB; i++) begin
              fr[1+i] = w[i];
              p = p ^ w[i];
            end
            if (PE != 0) fr[1+DB] = p[0];
            pos    = 0;
            active = 1;
          end
          if (push_ok) q.push_back(int'(in_data_v[g]) & ((1 << DB) - 1));
        end
        exp_txd[g]   = active ? int'(fr[pos / CPB]) : 1;
        exp_busy[g]  = active ? 1 : 0;
        exp_done[g]  = (active && pos == FL - 1) ? 1 : 0;
        exp_level[g] = q.size();
        exp_ready[g] = (q.size() < DEP) ? 1 : 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (started[k]) begin
          chk(k, "txd",      int'(txd_v[k]),   exp_txd[k]);
          chk(k, "busy",     int'(busy_v[k]),  exp_busy[k]);
          chk(k, "tx_done",  int'(done_v[k]),  exp_done[k]);
          chk(k, "level",    int'(level_v[k]), exp_level[k]);
          chk(k, "in_ready", int'(ready_v[k]), exp_ready[k]);
        end
      end
    end
  end

  // Single push into an idle block, then sample every bit mid-period and time the tx_done pulse.
  task automatic frame_test(input int k, input logic [8:0] w, input logic [15:0] eb,
                            input int nb, input int len);
    int t, c, done_at;
    logic [15:0] got;
    in_data_v[k]  = w;
    in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    t = 0;
    while (txd_v[k] !== 1'b0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk(k, "start_latency", t, 1);
    got = '1;
    done_at = 0;
    c = 1;
    while (done_at == 0 && c <= len + 20) begin
      if ((c - 1) % CPB == 8 && (c - 1) / CPB < nb) got[(c - 1) / CPB] = txd_v[k];
      if (done_v[k]) done_at = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk(k, "frame_len", done_at, len);
    chk(k, "frame_bits", int'(got & 16'((1 << nb) - 1)), int'(eb));
    @(negedge clk);
    chk(k, "busy_after", int'(busy_v[k]), 0);
    chk(k, "txd_after",  int'(txd_v[k]),  1);
  endtask

  initial begin
    int idx, el, dn, done_el, maxl, t, lows;
    bit acc, saw_full;

    rst = 1'b0;
    for (int k = 0; k < NC; k++) begin
      in_valid_v[k] = 1'b0;
      in_data_v[k]  = '0;
    end
    repeat (3) @(negedge clk);
    chk(0, "rst_txd",   int'(txd_v[0]),   1);
    chk(0, "rst_busy",  int'(busy_v[0]),  0);
    chk(0, "rst_done",  int'(done_v[0]),  0);
    chk(0, "rst_level", int'(level_v[0]), 0);
    chk(0, "rst_ready", int'(ready_v[0]), 1);
    rst = 1'b1;
    @(negedge clk);

    frame_test(0, 9'h0A5, 16'b1101001010,  10, 160);
    frame_test(1, 9'h007, 16'b11000001110, 11, 176);
    frame_test(2, 9'h007, 16'b10000001110, 11, 176);
    frame_test(3, 9'h055, 16'b1110101010,  10, 160);

    // Hold in_valid through six words with a four-deep FIFO.
    in_data_v[0]  = 9'h011;
    in_valid_v[0] = 1'b1;
    idx = 0; el = 0; dn = 0; done_el = -1; maxl = 0; saw_full = 0;
    while (el < 2000 && dn < 6) begin
      acc = (idx < 6) && ready_v[0];
      if (idx < 6 && !ready_v[0]) saw_full = 1;
      if (int'(level_v[0]) > maxl) maxl = int'(level_v[0]);
      if (done_v[0]) begin
        dn++;
        if (dn == 6) done_el = el;
      end
      @(negedge clk);
      el++;
      if (acc) begin
        idx++;
        if (idx < 6) in_data_v[0] = 9'(17 + idx);
        else in_valid_v[0] = 1'b0;
      end
    end
    in_valid_v[0] = 1'b0;
    chk(0, "t4_saw_full",  int'(saw_full), 1);
    chk(0, "t4_max_level", maxl, 4);
    chk(0, "t4_frames",    dn, 6);
    chk(0, "t4_span",      done_el, 961);
    @(negedge clk);

    // Push coinciding with a pop while two words are queued.
    in_data_v[0] = 9'h021; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_data_v[0] = 9'h022;
    @(negedge clk);
    in_data_v[0] = 9'h023;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk(0, "t6_level_pre", int'(level_v[0]), 2);
    t = 0;
    while (!done_v[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(0, "t6_done_seen", (t < 400) ? 1 : 0, 1);
    chk(0, "t6_level_at_pop", int'(level_v[0]), 2);
    in_data_v[0] = 9'h024; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk(0, "t6_level_post", int'(level_v[0]), 2);
    t = 0; dn = 0;
    while (busy_v[0] && t < 2000) begin
      if (done_v[0]) dn++;
      @(negedge clk);
      t++;
    end
    chk(0, "t6_frames", dn, 3);
    chk(0, "t6_idle", int'(busy_v[0]), 0);

    // Reset in the middle of the data bits with two words waiting.
    in_data_v[0] = 9'h03C; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_data_v[0] = 9'h041;
    @(negedge clk);
    in_data_v[0] = 9'h042;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk(0, "t5_level_pre", int'(level_v[0]), 2);
    repeat (48) @(negedge clk);
    chk(0, "t5_busy_pre", int'(busy_v[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk(0, "t5_txd",   int'(txd_v[0]),   1);
    chk(0, "t5_level", int'(level_v[0]), 0);
    chk(0, "t5_busy",  int'(busy_v[0]),  0);
    chk(0, "t5_done",  int'(done_v[0]),  0);
    lows = 0; dn = 0;
    repeat (400) begin
      @(negedge clk);
      if (!txd_v[0]) lows++;
      if (done_v[0]) dn++;
    end
    chk(0, "t5_no_tx",   lows, 0);
    chk(0, "t5_no_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
